// File: rtl/config_pkg.sv
// Minimal stand-in for the shared CVA6 configuration package.
// Provides only the fields this slice consumes.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN:          32,
    TRANS_ID_BITS: 3
  };

endpackage

// File: rtl/mult_wb_buffer_pkg.sv
// Local helpers for the multiplier writeback buffer.
// Encodes the per-cycle FIFO operation for the storage update.
package mult_wb_buffer_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE,
    FIFO_PUSH,
    FIFO_POP,
    FIFO_BOTH
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(
    input logic push,
    input logic pop
  );
    unique case ({push, pop})
      2'b10:   return FIFO_PUSH;
      2'b01:   return FIFO_POP;
      2'b11:   return FIFO_BOTH;
      default: return FIFO_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mult_wb_fifo.sv
// Synchronous FIFO with read/write pointers and occupancy count.
// Push/pop are pre-qualified by the owner; data storage is not reset.
module mult_wb_fifo
  import mult_wb_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  fifo_op_e         op;

  assign op      = fifo_op(push_i, pop_i);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      unique case (op)
        FIFO_PUSH: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          count_q  <= count_q + 1'b1;
        end
        FIFO_POP: begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          count_q  <= count_q - 1'b1;
        end
        FIFO_BOTH: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        default: begin
          count_q  <= count_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult_wb_buffer.sv
// Credit-controlled result buffer between the multiplier and the
// shared writeback port; the multiplier has no backpressure.
module mult_wb_buffer
  import mult_wb_buffer_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             mult_issue_i,
  output logic                             mult_ready_o,
  input  logic                             mult_valid_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0] mult_trans_id_i,
  input  logic [CVA6Cfg.XLEN-1:0]          mult_result_i,
  output logic                             wb_valid_o,
  input  logic                             wb_ready_i,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [CVA6Cfg.XLEN-1:0]          wb_result_o,
  output logic                             overflow_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned TIDW = CVA6Cfg.TRANS_ID_BITS;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TIDW-1:0] trans_id;
    logic [XLEN-1:0] result;
  } mult_wb_entry_t;

  mult_wb_entry_t wr_entry;
  mult_wb_entry_t rd_entry;
  logic [CW-1:0]  count;
  logic [CW:0]    credits;
  logic           pending_q;
  logic           flush_q;
  logic           pop;
  logic           push;
  logic           space;
  logic           stale;

  assign wr_entry = '{trans_id: mult_trans_id_i,
                      result:   mult_result_i};

  assign wb_valid_o    = (count != '0) & ~rst_i;
  assign wb_trans_id_o = rd_entry.trans_id;
  assign wb_result_o   = rd_entry.result;

  assign credits = {1'b0, count} + {{CW{1'b0}}, pending_q};
  assign mult_ready_o = (credits < (CW+1)'(DEPTH))
                      & ~flush_i & ~rst_i;

  assign pop   = wb_valid_o & wb_ready_i & ~flush_i;
  assign space = (count < CW'(DEPTH)) | pop;
  assign push  = mult_valid_i & ~flush_i & ~rst_i
               & pending_q & space;

  // A result right after a flush belongs to a discarded issue.
  assign stale = flush_q & ~pending_q;

  assign overflow_o = mult_valid_i & ~flush_i & ~rst_i
                    & ~push & ~stale;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      pending_q <= mult_issue_i & mult_ready_o & ~flush_i;
      flush_q   <= flush_i;
    end
  end

  mult_wb_fifo #(
    .WIDTH ($bits(mult_wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_entry),
    .data_o  (rd_entry),
    .count_o (count)
  );

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Directed self-checking bench for mult_wb_buffer.
// Drives the multiplier side by hand with one-cycle result latency.
module tb_mult_wb_buffer;

  localparam int unsigned XLEN = config_pkg::cva6_cfg_empty.XLEN;
  localparam int unsigned TIDW =
    config_pkg::cva6_cfg_empty.TRANS_ID_BITS;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            mult_issue_i;
  logic            mult_ready_o;
  logic            mult_valid_i;
  logic [TIDW-1:0] mult_trans_id_i;
  logic [XLEN-1:0] mult_result_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [TIDW-1:0] wb_trans_id_o;
  logic [XLEN-1:0] wb_result_o;
  logic            overflow_o;

  int checks   = 0;
  int failures = 0;

  mult_wb_buffer dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .mult_issue_i    (mult_issue_i),
    .mult_ready_o    (mult_ready_o),
    .mult_valid_i    (mult_valid_i),
    .mult_trans_id_i (mult_trans_id_i),
    .mult_result_i   (mult_result_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_trans_id_o   (wb_trans_id_o),
    .wb_result_o     (wb_result_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] res_of(input logic [TIDW-1:0] id);
    return {24'hC0FFEE, 5'b0, id};
  endfunction

  task automatic fill(input logic [TIDW-1:0] base);
    logic [TIDW-1:0] id;
    for (int c = 0; c < 6; c++) begin
      chk("fill_ready", 64'(mult_ready_o), 64'(c < 4));
      id = base + TIDW'(c - 1);
      mult_issue_i    = (c < 4);
      mult_valid_i    = (c >= 1) && (c <= 4);
      mult_trans_id_i = id;
      mult_result_i   = res_of(id);
      #1;
      chk("fill_overflow", 64'(overflow_o), 64'd0);
      tick();
    end
    mult_issue_i = 1'b0;
    mult_valid_i = 1'b0;
    chk("fill_count", 64'(dut.count), 64'd4);
    chk("fill_ready_low", 64'(mult_ready_o), 64'd0);
  endtask

  task automatic drain(input logic [TIDW-1:0] base, input int n);
    logic [TIDW-1:0] id;
    wb_ready_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      id = base + TIDW'(k);
      chk("drain_valid", 64'(wb_valid_o), 64'd1);
      chk("drain_id", 64'(wb_trans_id_o), 64'(id));
      chk("drain_result", 64'(wb_result_o), 64'(res_of(id)));
      tick();
    end
    wb_ready_i = 1'b0;
  endtask

  initial begin
    rst_i           = 1'b1;
    flush_i         = 1'b0;
    mult_issue_i    = 1'b0;
    mult_valid_i    = 1'b0;
    mult_trans_id_i = '0;
    mult_result_i   = '0;
    wb_ready_i      = 1'b0;
    tick();
    tick();
    chk("rst_ready", 64'(mult_ready_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("post_rst_ready", 64'(mult_ready_o), 64'd1);
    chk("post_rst_count", 64'(dut.count), 64'd0);

    // Single operation
    mult_issue_i = 1'b1;
    tick();
    mult_issue_i    = 1'b0;
    mult_valid_i    = 1'b1;
    mult_trans_id_i = 3'd3;
    mult_result_i   = 32'h2A;
    #1;
    chk("single_no_bypass", 64'(wb_valid_o), 64'd0);
    chk("single_overflow", 64'(overflow_o), 64'd0);
    tick();
    mult_valid_i = 1'b0;
    wb_ready_i   = 1'b1;
    chk("single_valid", 64'(wb_valid_o), 64'd1);
    chk("single_id", 64'(wb_trans_id_o), 64'd3);
    chk("single_result", 64'(wb_result_o), 64'h2A);
    tick();
    wb_ready_i = 1'b0;
    chk("single_empty", 64'(wb_valid_o), 64'd0);
    chk("single_count", 64'(dut.count), 64'd0);

    // Fill to DEPTH and drain in order
    fill(3'd0);
    tick();
    chk("hold_id", 64'(wb_trans_id_o), 64'd0);
    chk("hold_result", 64'(wb_result_o), 64'(res_of(3'd0)));
    drain(3'd0, 4);
    chk("drained", 64'(wb_valid_o), 64'd0);

    // Full FIFO with simultaneous push and pop
    fill(3'd4);
    wb_ready_i = 1'b1;
    force dut.pending_q = 1'b1;
    mult_valid_i    = 1'b1;
    mult_trans_id_i = 3'd0;
    mult_result_i   = res_of(3'd0);
    #1;
    chk("full_pp_overflow", 64'(overflow_o), 64'd0);
    chk("full_pp_head", 64'(wb_trans_id_o), 64'd4);
    tick();
    release dut.pending_q;
    mult_valid_i = 1'b0;
    wb_ready_i   = 1'b0;
    chk("full_pp_count", 64'(dut.count), 64'd4);
    drain(3'd5, 4);
    chk("full_pp_empty", 64'(wb_valid_o), 64'd0);
    tick();

    // Flush with two entries and one pending
    mult_issue_i = 1'b1;
    tick();
    mult_valid_i    = 1'b1;
    mult_trans_id_i = 3'd1;
    mult_result_i   = res_of(3'd1);
    tick();
    mult_trans_id_i = 3'd2;
    mult_result_i   = res_of(3'd2);
    tick();
    mult_issue_i    = 1'b0;
    flush_i         = 1'b1;
    mult_trans_id_i = 3'd3;
    mult_result_i   = res_of(3'd3);
    #1;
    chk("flush_cycle_count", 64'(dut.count), 64'd2);
    chk("flush_cycle_valid", 64'(wb_valid_o), 64'd1);
    chk("flush_cycle_ready", 64'(mult_ready_o), 64'd0);
    chk("flush_cycle_ovf", 64'(overflow_o), 64'd0);
    tick();
    flush_i         = 1'b0;
    mult_trans_id_i = 3'd5;
    mult_result_i   = res_of(3'd5);
    #1;
    chk("post_flush_valid", 64'(wb_valid_o), 64'd0);
    chk("post_flush_ready", 64'(mult_ready_o), 64'd1);
    chk("late_valid_ovf", 64'(overflow_o), 64'd0);
    tick();
    mult_valid_i = 1'b0;
    chk("late_valid_drop", 64'(wb_valid_o), 64'd0);
    chk("late_valid_count", 64'(dut.count), 64'd0);

    // Unexpected result while full
    fill(3'd0);
    mult_valid_i    = 1'b1;
    mult_trans_id_i = 3'd6;
    mult_result_i   = res_of(3'd6);
    #1;
    chk("forced_ovf", 64'(overflow_o), 64'd1);
    tick();
    mult_valid_i = 1'b0;
    #1;
    chk("forced_ovf_pulse", 64'(overflow_o), 64'd0);
    chk("forced_count", 64'(dut.count), 64'd4);
    chk("forced_head", 64'(wb_trans_id_o), 64'd0);

    // Reset mid-operation with three entries
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk("pre_rst_count", 64'(dut.count), 64'd3);
    rst_i   = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("mid_rst_valid", 64'(wb_valid_o), 64'd0);
    chk("mid_rst_count", 64'(dut.count), 64'd0);
    chk("mid_rst_ready", 64'(mult_ready_o), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("resume_ready", 64'(mult_ready_o), 64'd1);
    mult_issue_i = 1'b1;
    tick();
    mult_issue_i    = 1'b0;
    mult_valid_i    = 1'b1;
    mult_trans_id_i = 3'd6;
    mult_result_i   = 32'h55;
    tick();
    mult_valid_i = 1'b0;
    chk("resume_id", 64'(wb_trans_id_o), 64'd6);
    chk("resume_result", 64'(wb_result_o), 64'h55);
    chk("resume_count", 64'(dut.count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
